// File: rtl/mips_mc_controller.sv
// rtl/mips_mc_controller.sv - multicycle MIPS control FSM with memory-ready stall and illegal-op flag
module mips_mc_controller #(
  parameter bit HAS_BNE       = 1'b1,
  parameter bit HAS_IMM_LOGIC = 1'b1,
  parameter bit MEM_WAIT      = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       memwrite,
  output logic       iord,
  output logic       irwrite,
  output logic       pcen,
  output logic [1:0] pcsrc,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic       signOrZero,
  output logic [2:0] alucontrol,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       illegal
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_RTYPEEX, S_RTYPEWB, S_BRANCH, S_IMMEX, S_IMMWB, S_JUMP
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_t state, next_state;
  logic   ill_next;
  logic   ready;
  logic   is_bne, is_imm_logic, is_imm, funct_legal;
  logic   mem_req_s, memwrite_s, irwrite_s, regwrite_s, pcwrite, branch;

  assign ready        = MEM_WAIT ? mem_ready : 1'b1;
  assign is_bne       = HAS_BNE && (op == OP_BNE);
  assign is_imm_logic = HAS_IMM_LOGIC && ((op == OP_ANDI) || (op == OP_ORI) || (op == OP_SLTI));
  assign is_imm       = (op == OP_ADDI) || is_imm_logic;
  assign funct_legal  = (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND) ||
                        (funct == FN_OR)  || (funct == FN_SLT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_FETCH;
      illegal <= 1'b0;
    end else begin
      state   <= next_state;
      illegal <= ill_next;
    end
  end

  always_comb begin
    next_state = S_FETCH;
    ill_next   = 1'b0;
    case (state)
      S_FETCH:  next_state = ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if ((op == OP_LW) || (op == OP_SW))        next_state = S_MEMADR;
        else if (op == OP_RTYPE)                   next_state = S_RTYPEEX;
        else if ((op == OP_BEQ) || is_bne)         next_state = S_BRANCH;
        else if (is_imm)                           next_state = S_IMMEX;
        else if (op == OP_J)                       next_state = S_JUMP;
        else                                       ill_next   = 1'b1;
      end
      S_MEMADR:  next_state = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   next_state = ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:   next_state = ready ? S_FETCH : S_MEMWR;
      S_RTYPEEX: begin
        if (funct_legal) next_state = S_RTYPEWB;
        else             ill_next   = 1'b1;
      end
      S_IMMEX:   next_state = S_IMMWB;
      default:   next_state = S_FETCH;
    endcase
  end

  always_comb begin
    mem_req_s  = 1'b0;
    memwrite_s = 1'b0;
    irwrite_s  = 1'b0;
    regwrite_s = 1'b0;
    pcwrite    = 1'b0;
    branch     = 1'b0;
    iord       = 1'b0;
    pcsrc      = 2'b00;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    signOrZero = 1'b0;
    alucontrol = ALU_ADD;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    case (state)
      S_FETCH: begin
        mem_req_s = 1'b1;
        alusrcb   = 2'b01;
        irwrite_s = ready;
        pcwrite   = ready;
      end
      S_DECODE:  alusrcb = 2'b11;
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_MEMRD: begin
        mem_req_s = 1'b1;
        iord      = 1'b1;
      end
      S_MEMWB: begin
        regwrite_s = 1'b1;
        memtoreg   = 1'b1;
      end
      S_MEMWR: begin
        mem_req_s  = 1'b1;
        memwrite_s = 1'b1;
        iord       = 1'b1;
      end
      S_RTYPEEX: begin
        alusrca = 1'b1;
        case (funct)
          FN_SUB:  alucontrol = ALU_SUB;
          FN_AND:  alucontrol = ALU_AND;
          FN_OR:   alucontrol = ALU_OR;
          FN_SLT:  alucontrol = ALU_SLT;
          default: alucontrol = ALU_ADD;
        endcase
      end
      S_RTYPEWB: begin
        regwrite_s = 1'b1;
        regdst     = 1'b1;
      end
      S_BRANCH: begin
        alusrca    = 1'b1;
        alucontrol = ALU_SUB;
        pcsrc      = 2'b01;
        branch     = 1'b1;
      end
      S_IMMEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        case (op)
          OP_ANDI: begin alucontrol = ALU_AND; signOrZero = 1'b1; end
          OP_ORI:  begin alucontrol = ALU_OR;  signOrZero = 1'b1; end
          OP_SLTI: alucontrol = ALU_SLT;
          default: alucontrol = ALU_ADD;
        endcase
      end
      S_IMMWB:   regwrite_s = 1'b1;
      S_JUMP: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
      end
      default: ;
    endcase
  end

  // Strobes are gated by reset so an in-flight access or write dies the instant reset asserts.
  assign mem_req  = reset & mem_req_s;
  assign memwrite = reset & memwrite_s;
  assign irwrite  = reset & irwrite_s;
  assign regwrite = reset & regwrite_s;
  assign pcen     = reset & (pcwrite | (branch & (zero ^ is_bne)));

endmodule

// File: tb/tb_mips_mc_controller.sv
// tb/tb_mips_mc_controller.sv - table-driven check of the multicycle controller state sequences
module tb_mips_mc_controller;

  logic       clk, reset, zero, mem_ready;
  logic [5:0] op, funct;

  logic       a_mem_req, a_memwrite, a_iord, a_irwrite, a_pcen, a_alusrca, a_soz;
  logic       a_regdst, a_memtoreg, a_regwrite, a_illegal;
  logic [1:0] a_pcsrc, a_alusrcb;
  logic [2:0] a_alu;
  logic       b_mem_req, b_memwrite, b_iord, b_irwrite, b_pcen, b_alusrca, b_soz;
  logic       b_regdst, b_memtoreg, b_regwrite, b_illegal;
  logic [1:0] b_pcsrc, b_alusrcb;
  logic [2:0] b_alu;

  mips_mc_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .mem_req(a_mem_req), .memwrite(a_memwrite), .iord(a_iord), .irwrite(a_irwrite),
    .pcen(a_pcen), .pcsrc(a_pcsrc), .alusrca(a_alusrca), .alusrcb(a_alusrcb),
    .signOrZero(a_soz), .alucontrol(a_alu), .regdst(a_regdst), .memtoreg(a_memtoreg),
    .regwrite(a_regwrite), .illegal(a_illegal)
  );

  mips_mc_controller #(.HAS_BNE(1'b0), .HAS_IMM_LOGIC(1'b0), .MEM_WAIT(1'b0)) dut_b (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .mem_req(b_mem_req), .memwrite(b_memwrite), .iord(b_iord), .irwrite(b_irwrite),
    .pcen(b_pcen), .pcsrc(b_pcsrc), .alusrca(b_alusrca), .alusrcb(b_alusrcb),
    .signOrZero(b_soz), .alucontrol(b_alu), .regdst(b_regdst), .memtoreg(b_memtoreg),
    .regwrite(b_regwrite), .illegal(b_illegal)
  );

  // {mem_req,memwrite,iord,irwrite,pcen,pcsrc,alusrca,alusrcb,signOrZero,alucontrol,regdst,memtoreg,regwrite,illegal}
  logic [17:0] outs_a, outs_b;
  assign outs_a = {a_mem_req, a_memwrite, a_iord, a_irwrite, a_pcen, a_pcsrc, a_alusrca, a_alusrcb,
                   a_soz, a_alu, a_regdst, a_memtoreg, a_regwrite, a_illegal};
  assign outs_b = {b_mem_req, b_memwrite, b_iord, b_irwrite, b_pcen, b_pcsrc, b_alusrca, b_alusrcb,
                   b_soz, b_alu, b_regdst, b_memtoreg, b_regwrite, b_illegal};

  localparam logic [17:0] E_RESET  = 18'b0_0_0_0_0_00_0_01_0_010_0_0_0_0;
  localparam logic [17:0] E_FETCH  = 18'b1_0_0_1_1_00_0_01_0_010_0_0_0_0;
  localparam logic [17:0] E_FSTALL = 18'b1_0_0_0_0_00_0_01_0_010_0_0_0_0;
  localparam logic [17:0] E_DECODE = 18'b0_0_0_0_0_00_0_11_0_010_0_0_0_0;
  localparam logic [17:0] E_MEMADR = 18'b0_0_0_0_0_00_1_10_0_010_0_0_0_0;
  localparam logic [17:0] E_MEMRD  = 18'b1_0_1_0_0_00_0_00_0_010_0_0_0_0;
  localparam logic [17:0] E_MEMWB  = 18'b0_0_0_0_0_00_0_00_0_010_0_1_1_0;
  localparam logic [17:0] E_MEMWR  = 18'b1_1_1_0_0_00_0_00_0_010_0_0_0_0;
  localparam logic [17:0] E_RADD   = 18'b0_0_0_0_0_00_1_00_0_010_0_0_0_0;
  localparam logic [17:0] E_RSUB   = 18'b0_0_0_0_0_00_1_00_0_110_0_0_0_0;
  localparam logic [17:0] E_RAND   = 18'b0_0_0_0_0_00_1_00_0_000_0_0_0_0;
  localparam logic [17:0] E_ROR    = 18'b0_0_0_0_0_00_1_00_0_001_0_0_0_0;
  localparam logic [17:0] E_RSLT   = 18'b0_0_0_0_0_00_1_00_0_111_0_0_0_0;
  localparam logic [17:0] E_RWB    = 18'b0_0_0_0_0_00_0_00_0_010_1_0_1_0;
  localparam logic [17:0] E_BR_T   = 18'b0_0_0_0_1_01_1_00_0_110_0_0_0_0;
  localparam logic [17:0] E_BR_N   = 18'b0_0_0_0_0_01_1_00_0_110_0_0_0_0;
  localparam logic [17:0] E_ADDI   = 18'b0_0_0_0_0_00_1_10_0_010_0_0_0_0;
  localparam logic [17:0] E_ANDI   = 18'b0_0_0_0_0_00_1_10_1_000_0_0_0_0;
  localparam logic [17:0] E_ORI    = 18'b0_0_0_0_0_00_1_10_1_001_0_0_0_0;
  localparam logic [17:0] E_SLTI   = 18'b0_0_0_0_0_00_1_10_0_111_0_0_0_0;
  localparam logic [17:0] E_IMMWB  = 18'b0_0_0_0_0_00_0_00_0_010_0_0_1_0;
  localparam logic [17:0] E_JUMP   = 18'b0_0_0_0_1_10_0_00_0_010_0_0_0_0;
  localparam logic [17:0] ILL      = 18'b0_0_0_0_0_00_0_00_0_000_0_0_0_1;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000, BEQ = 6'b000100;
  localparam logic [5:0] BNE = 6'b000101, ADDI = 6'b001000, ANDI = 6'b001100, ORI = 6'b001101;
  localparam logic [5:0] SLTI = 6'b001010, JMP = 6'b000010, BAD = 6'b111111;

  typedef struct {
    string       name;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        zero;
    logic        ready;
    logic [17:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input string n, input logic [5:0] o, input logic [5:0] f,
                     input logic z, input logic r, input logic [17:0] e);
    vec_t v;
    v.name = n; v.op = o; v.funct = f; v.zero = z; v.ready = r; v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic check(input string n, input logic [17:0] got, input logic [17:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", n, got, exp);
    end
  endtask

  // One clock cycle: drive inputs, sample mid-cycle at the falling edge, then advance.
  task automatic cyc(input string n, input logic [5:0] o, input logic [5:0] f, input logic z,
                     input logic r, input logic [17:0] ea, input bit chk_b, input logic [17:0] eb);
    op = o; funct = f; zero = z; mem_ready = r;
    @(negedge clk);
    check(n, outs_a, ea);
    if (chk_b) check({n, "_b"}, outs_b, eb);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  initial begin
    logic [5:0]  rf[5];
    logic [17:0] rx[5];
    rf = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    rx = '{E_RADD, E_RSUB, E_RAND, E_ROR, E_RSLT};

    add("lw_f", LW, 0, 0, 1, E_FETCH);   add("lw_d", LW, 0, 0, 1, E_DECODE);
    add("lw_ma", LW, 0, 0, 1, E_MEMADR); add("lw_mr", LW, 0, 0, 1, E_MEMRD);
    add("lw_wb", LW, 0, 0, 1, E_MEMWB);
    add("sw_f", SW, 0, 0, 1, E_FETCH);   add("sw_d", SW, 0, 0, 1, E_DECODE);
    add("sw_ma", SW, 0, 0, 1, E_MEMADR);
    for (int i = 0; i < 3; i++) add("sw_stall", SW, 0, 0, 0, E_MEMWR);
    add("sw_done", SW, 0, 0, 1, E_MEMWR);
    add("r_fstall", RT, rf[0], 0, 0, E_FSTALL);
    for (int i = 0; i < 5; i++) begin
      add("r_f", RT, rf[i], 0, 1, E_FETCH); add("r_d", RT, rf[i], 0, 1, E_DECODE);
      add("r_ex", RT, rf[i], 0, 1, rx[i]);  add("r_wb", RT, rf[i], 0, 1, E_RWB);
    end
    add("beq1_f", BEQ, 0, 1, 1, E_FETCH); add("beq1_d", BEQ, 0, 1, 1, E_DECODE);
    add("beq1_br", BEQ, 0, 1, 1, E_BR_T);
    add("beq0_f", BEQ, 0, 0, 1, E_FETCH); add("beq0_d", BEQ, 0, 0, 1, E_DECODE);
    add("beq0_br", BEQ, 0, 0, 1, E_BR_N);
    add("bne1_f", BNE, 0, 1, 1, E_FETCH); add("bne1_d", BNE, 0, 1, 1, E_DECODE);
    add("bne1_br", BNE, 0, 1, 1, E_BR_N);
    add("bne0_f", BNE, 0, 0, 1, E_FETCH); add("bne0_d", BNE, 0, 0, 1, E_DECODE);
    add("bne0_br", BNE, 0, 0, 1, E_BR_T);
    add("addi_f", ADDI, 0, 0, 1, E_FETCH); add("addi_d", ADDI, 0, 0, 1, E_DECODE);
    add("addi_ex", ADDI, 0, 0, 1, E_ADDI); add("addi_wb", ADDI, 0, 0, 1, E_IMMWB);
    add("andi_f", ANDI, 0, 0, 1, E_FETCH); add("andi_d", ANDI, 0, 0, 1, E_DECODE);
    add("andi_ex", ANDI, 0, 0, 1, E_ANDI); add("andi_wb", ANDI, 0, 0, 1, E_IMMWB);
    add("ori_f", ORI, 0, 0, 1, E_FETCH);   add("ori_d", ORI, 0, 0, 1, E_DECODE);
    add("ori_ex", ORI, 0, 0, 1, E_ORI);    add("ori_wb", ORI, 0, 0, 1, E_IMMWB);
    add("slti_f", SLTI, 0, 0, 1, E_FETCH); add("slti_d", SLTI, 0, 0, 1, E_DECODE);
    add("slti_ex", SLTI, 0, 0, 1, E_SLTI); add("slti_wb", SLTI, 0, 0, 1, E_IMMWB);
    add("j_f", JMP, 0, 0, 1, E_FETCH);     add("j_d", JMP, 0, 0, 1, E_DECODE);
    add("j_jump", JMP, 0, 0, 1, E_JUMP);
    add("badop_f", BAD, 0, 0, 1, E_FETCH); add("badop_d", BAD, 0, 0, 1, E_DECODE);
    add("badop_ill", BAD, 0, 0, 0, E_FSTALL | ILL);
    add("badfn_f", RT, 6'b000011, 0, 1, E_FETCH);
    add("badfn_d", RT, 6'b000011, 0, 1, E_DECODE);
    add("badfn_ex", RT, 6'b000011, 0, 1, E_RADD);
    add("badfn_ill", RT, 6'b000011, 0, 0, E_FSTALL | ILL);
    add("after_ill", LW, 0, 0, 1, E_FETCH);

    op = LW; funct = 0; zero = 0; mem_ready = 1; reset = 1'b0;
    @(negedge clk);
    check("reset_a", outs_a, E_RESET);
    check("reset_b", outs_b, E_RESET);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    foreach (vecs[i]) cyc(vecs[i].name, vecs[i].op, vecs[i].funct, vecs[i].zero,
                          vecs[i].ready, vecs[i].exp, 1'b0, '0);

    // Reduced variant: bne/andi/ori/slti illegal, mem_ready ignored; full variant stalls in FETCH.
    do_reset();
    cyc("nb_bne_f", BNE, 0, 1, 0, E_FSTALL, 1'b1, E_FETCH);
    cyc("nb_bne_d", BNE, 0, 1, 0, E_FSTALL, 1'b1, E_DECODE);
    cyc("nb_bne_ill", ORI, 0, 1, 0, E_FSTALL, 1'b1, E_FETCH | ILL);
    cyc("nb_ori_d", ORI, 0, 0, 0, E_FSTALL, 1'b1, E_DECODE);
    cyc("nb_ori_ill", ADDI, 0, 0, 0, E_FSTALL, 1'b1, E_FETCH | ILL);
    cyc("nb_addi_d", ADDI, 0, 0, 0, E_FSTALL, 1'b1, E_DECODE);
    cyc("nb_addi_ex", ADDI, 0, 0, 0, E_FSTALL, 1'b1, E_ADDI);
    cyc("nb_addi_wb", ADDI, 0, 0, 0, E_FSTALL, 1'b1, E_IMMWB);
    cyc("nb_fetch", SW, 0, 0, 0, E_FSTALL, 1'b1, E_FETCH);

    // Reset asserted mid-cycle during a MEMWR stall must drop the strobes without a clock edge.
    do_reset();
    cyc("ab_f", SW, 0, 0, 1, E_FETCH, 1'b0, '0);
    cyc("ab_d", SW, 0, 0, 1, E_DECODE, 1'b0, '0);
    cyc("ab_ma", SW, 0, 0, 1, E_MEMADR, 1'b0, '0);
    mem_ready = 1'b0;
    #2;
    check("ab_stall", outs_a, E_MEMWR);
    reset = 1'b0;
    #1;
    check("ab_drop", {a_mem_req, a_memwrite}, 18'd0);
    check("ab_reset", outs_a, E_RESET);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    cyc("ab_refetch", SW, 0, 0, 1, E_FETCH, 1'b0, '0);
    cyc("ab_redecode", SW, 0, 0, 1, E_DECODE, 1'b0, '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
